// File: rtl/water_dispenser_multi_pkg.sv
// Shared definitions for the multi-outlet water dispenser: state encoding,
// width/tick derivations and the switch-bank digit encoder.
package water_dispenser_multi_pkg;

    localparam logic [1:0] READING_INPUT = 2'd0;
    localparam logic [1:0] DISPENSING    = 2'd1;
    localparam logic [1:0] PAUSED        = 2'd2;

    typedef struct packed {
        logic       valid;
        logic [3:0] digit;
    } digit_t;

    function automatic int unsigned amount_width(input int unsigned digits);
        longint unsigned limit;
        limit = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            limit = limit * 10;
        end
        return $clog2(limit);
    endfunction

    function automatic int unsigned ch_width(input int unsigned channels);
        return (channels <= 1) ? 1 : $clog2(channels);
    endfunction

    function automatic int unsigned ticks_per_ml(input int unsigned ns_per_ml,
                                                 input int unsigned period_ns);
        return ns_per_ml / period_ns;
    endfunction

    // Lowest-index set switch wins; scanning downward lets it overwrite higher ones.
    function automatic digit_t encode_digit(input logic [9:0] switches);
        digit_t result;
        result = '0;
        for (int i = 9; i >= 0; i--) begin
            if (switches[i]) begin
                result.valid = 1'b1;
                result.digit = 4'(i);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ml_tick_generator.sv
// Per-millilitre timer: pulses tick on the last enabled cycle of each millilitre.
module ml_tick_generator #(
    parameter int unsigned TICKS_PER_ML = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CNT_W = (TICKS_PER_ML > 1) ? $clog2(TICKS_PER_ML) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_ML - 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign tick = enable && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = tick ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/water_dispenser_multi.sv
// Multi-outlet dispenser controller: decimal volume entry, channel latch,
// timed one-hot valve drive with pause/resume and cancel.
module water_dispenser_multi
    import water_dispenser_multi_pkg::*;
#(
    parameter int unsigned CHANNEL_COUNT      = 2,
    parameter int unsigned DIGIT_COUNT        = 4,
    parameter int unsigned NS_PER_ML          = 100,
    parameter int unsigned CLOCK_PERIOD_IN_NS = 20,
    localparam int unsigned CH_W              = ch_width(CHANNEL_COUNT),
    localparam int unsigned AMOUNT_W          = amount_width(DIGIT_COUNT)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [9:0]               switches,
    input  logic [CH_W-1:0]          channel_select,
    input  logic                     add_pressed,
    input  logic                     ok_pressed,
    input  logic                     cancel_pressed,
    input  logic                     pause_pressed,
    output logic [AMOUNT_W-1:0]      amount_in_ml,
    output logic [AMOUNT_W-1:0]      remaining_in_ml,
    output logic [CHANNEL_COUNT-1:0] valve,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned TICKS_PER_ML = ticks_per_ml(NS_PER_ML, CLOCK_PERIOD_IN_NS);
    localparam int unsigned COUNT_W = $clog2(DIGIT_COUNT + 1);
    localparam logic [COUNT_W-1:0] MAX_DIGITS = COUNT_W'(DIGIT_COUNT);
    localparam logic [CH_W:0] CHANNEL_LIMIT = (CH_W + 1)'(CHANNEL_COUNT);

    logic [1:0]          state_q, state_d;
    logic [AMOUNT_W-1:0] amount_q, amount_d;
    logic [AMOUNT_W-1:0] remaining_q, remaining_d;
    logic [COUNT_W-1:0]  digit_count_q, digit_count_d;
    logic [CH_W-1:0]     channel_q, channel_d;
    logic                done_q, done_d;

    logic   win_ok, win_pause, win_add;
    logic   accept_ok, tick, tick_enable, tick_clear;
    digit_t dig;

    // One pulse wins per cycle; a winner that is ignored in the current state blocks the rest.
    assign win_ok    = ok_pressed && !cancel_pressed;
    assign win_pause = pause_pressed && !cancel_pressed && !ok_pressed;
    assign win_add   = add_pressed && !cancel_pressed && !ok_pressed && !pause_pressed;
    assign dig       = encode_digit(switches);

    assign accept_ok = (state_q == READING_INPUT) && win_ok && (amount_q != '0)
                       && ({1'b0, channel_select} < CHANNEL_LIMIT);
    assign tick_enable = (state_q == DISPENSING) && !cancel_pressed;
    assign tick_clear  = accept_ok || cancel_pressed;

    ml_tick_generator #(
        .TICKS_PER_ML(TICKS_PER_ML)
    ) u_ml_tick_generator (
        .clock (clock),
        .reset (reset),
        .clear (tick_clear),
        .enable(tick_enable),
        .tick  (tick)
    );

    always_comb begin
        state_d       = state_q;
        amount_d      = amount_q;
        remaining_d   = remaining_q;
        digit_count_d = digit_count_q;
        channel_d     = channel_q;
        done_d        = 1'b0;

        case (state_q)
            READING_INPUT: begin
                if (cancel_pressed) begin
                    amount_d      = '0;
                    digit_count_d = '0;
                end else if (accept_ok) begin
                    channel_d   = channel_select;
                    remaining_d = amount_q;
                    state_d     = DISPENSING;
                end else if (win_add && dig.valid && (digit_count_q < MAX_DIGITS)) begin
                    amount_d = amount_q * AMOUNT_W'(10) + AMOUNT_W'(dig.digit);
                    // Digits count from the first nonzero one, so leading zeros are free.
                    if ((amount_q != '0) || (dig.digit != 4'd0)) begin
                        digit_count_d = digit_count_q + COUNT_W'(1);
                    end
                end
            end
            DISPENSING, PAUSED: begin
                if (cancel_pressed) begin
                    amount_d      = '0;
                    remaining_d   = '0;
                    digit_count_d = '0;
                    state_d       = READING_INPUT;
                end else if (tick && (remaining_q == AMOUNT_W'(1))) begin
                    amount_d      = '0;
                    remaining_d   = '0;
                    digit_count_d = '0;
                    done_d        = 1'b1;
                    state_d       = READING_INPUT;
                end else begin
                    if (tick) begin
                        remaining_d = remaining_q - AMOUNT_W'(1);
                    end
                    if (win_pause) begin
                        state_d = (state_q == DISPENSING) ? PAUSED : DISPENSING;
                    end
                end
            end
            default: begin
                state_d = READING_INPUT;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= READING_INPUT;
            amount_q      <= '0;
            remaining_q   <= '0;
            digit_count_q <= '0;
            channel_q     <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            amount_q      <= amount_d;
            remaining_q   <= remaining_d;
            digit_count_q <= digit_count_d;
            channel_q     <= channel_d;
            done_q        <= done_d;
        end
    end

    // Decoded from registered state so an asynchronous reset closes the valve at once.
    always_comb begin
        valve = '0;
        for (int i = 0; i < CHANNEL_COUNT; i++) begin
            valve[i] = (state_q == DISPENSING) && (channel_q == CH_W'(i));
        end
    end

    assign amount_in_ml    = amount_q;
    assign remaining_in_ml = remaining_q;
    assign busy            = (state_q != READING_INPUT);
    assign done            = done_q;

endmodule
